chacha20_poly1305_mac_fmt: RTL and testbench
============================================

Name: chacha20_poly1305_mac_fmt

Overview:
- Message formatter that sits directly upstream of the Poly1305 MAC engine in the ChaCha20-Poly1305 AEAD datapath.
- Accepts the AAD stream, then the ciphertext stream, as 128-bit blocks.
- Zero-pads each stream to a 16-byte boundary and forwards the blocks to Poly1305.
- Appends the final length block le64(aad_len) || le64(ct_len) per RFC 8439 §2.8.

Parameters:
- None. Block size is fixed at 16 bytes by RFC 8439.

Ports:
- clk        in   1    clock
- reset_n    in   1    synchronous, active-low reset
- start      in   1    one-cycle pulse: clear counters, enter AAD phase; restarts from any state
- in_valid   in   1    input block valid
- in_ready   out  1    input block accepted when in_valid && in_ready
- in_data    in   128  input block; byte 0 at bits [127:120]
- in_last    in   1    last block of current phase (AAD or CT)
- in_bytes   in   5    valid bytes in block, 0..16; must be 16 when in_last=0
- out_valid  out  1    output block valid to Poly1305
- out_ready  in   1    Poly1305 accepts block
- out_data   out  128  padded block or length block
- out_last   out  1    marks the length block (final Poly1305 block)
- done       out  1    level; high after the length block is handshaken, until next start
- error      out  1    sticky protocol error, cleared by start
- aad_len    out  64   running AAD byte count
- ct_len     out  64   running CT byte count

Behaviour:
- Reset: all registered outputs are 0 (out_valid, out_data, out_last, done, error, aad_len, ct_len). State is IDLE.
- States: IDLE, AAD, CT, LEN, DONE.
  - IDLE/DONE --start--> AAD.
  - AAD --accepted in_last--> CT.
  - CT --accepted in_last--> LEN.
  - LEN --length block loaded into output reg--> wait for handshake --> DONE.
- start in any state:
  - Clears counters, error, done, out_valid and out_last.
  - Discards any pending output block.
  - Enters AAD. start has priority over any same-cycle handshake.
- in_ready = (state is AAD or CT) && (!out_valid || out_ready). It is combinational on out_ready; there is no skid buffer.
- Accepted block with in_bytes = n (1..16):
  - out_data keeps the upper n bytes of in_data; the lower 16-n bytes are zero.
  - out_valid rises the next cycle (latency 1).
  - The phase counter adds n.
- Accepted block with in_bytes = 0:
  - Legal only with in_last=1 (empty AAD or empty CT).
  - Produces no output block and does not change the counter.
  - Advances the phase.
- Protocol violations:
  - The violations are in_bytes > 16, or in_last=0 with in_bytes != 16.
  - Either one sets error for that beat.
  - The block is still consumed, with in_bytes clamped to 16; no other effect.
- Output register:
  - Holds out_data, out_valid and out_last stable until out_ready.
  - The output reg reloads in the same cycle a handshake completes (full throughput: 1 block/cycle).
- LEN state:
  - When the output reg is free, load out_data[127:64] = byte-swapped aad_len and out_data[63:0] = byte-swapped ct_len (little-endian bytes), with out_last=1.
  - in_ready=0 throughout LEN and DONE.
- done rises the cycle after the length block handshake.
- in_valid in IDLE/DONE is ignored (in_ready=0).
- Counters are 64-bit and wrap modulo 2^64. No saturation.
- aad_len and ct_len are visible in every state and hold their values through DONE.

Test Plan:
- RFC 8439 §2.8.2 vector, fed as start, then AAD of 12 bytes (one beat, in_bytes=12, in_last=1), then CT of 114 bytes (7×16 plus a last beat of 2). Required response:
  - 10 output blocks in total.
  - Block 0 has its low 4 bytes zero.
  - Block 8 has its low 14 bytes zero.
  - Block 9 = 0x0c00000000000000_7200000000000000 with out_last=1.
  - done=1, aad_len=12, ct_len=114.
- Empty AAD: start, then an AAD beat with in_bytes=0, in_last=1, then a CT beat of 16 bytes with last. Required response: exactly 2 outputs; the length block is 0x0000000000000000_1000000000000000.
- Backpressure: hold out_ready=0 for 5 cycles mid-CT. Required response: in_ready=0, and out_data/out_valid stay stable; after release there is no loss or duplication, and the block sequence matches the case with no stall.
- Protocol error: a non-last beat with in_bytes=8. Required response: error=1 (sticky), ct_len increments by 16; a subsequent start clears error.
- Restart mid-CT: start while out_valid=1. Required response: out_valid=0 next cycle, counters 0, state AAD; the next stream formats correctly.
- Reset mid-operation: reset_n=0 for 1 cycle during LEN. Required response: every output is 0 the next cycle, and in_ready stays 0 until start.

Source files
------------

// File: rtl/chacha20_poly1305_mac_fmt_if.sv
// Block stream bundle between the AEAD datapath, the MAC formatter and Poly1305.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
//
// Ports (modport slave = formatter side):
//   in_valid/in_ready/in_data/in_last/in_bytes : AAD or CT block input
//   out_valid/out_ready/out_data/out_last      : padded or length block to Poly1305
interface chacha20_poly1305_mac_fmt_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic [4:0]   in_bytes;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;

    modport master (
        output in_valid, in_data, in_last, in_bytes, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, in_bytes, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/chacha20_poly1305_mac_fmt.sv
// Poly1305 message formatter: zero-pads AAD and CT blocks, appends le64(aad_len)||le64(ct_len).
// Latency: 1 cycle from accepted input block to out_valid; length block loads as soon as the output reg frees.
// Backpressure: single output register, in_ready = AAD/CT phase && (!out_valid || out_ready); no skid buffer.
//
// Ports:
//   clk, reset_n    : clock, synchronous active-low reset
//   start           : pulse, restarts a message from any state (wins over same-cycle handshakes)
//   bus (slave)     : input block stream and output block stream
//   done            : level, set after the length block is handshaken, cleared by start
//   error           : sticky protocol error, cleared by start
//   aad_len, ct_len : running byte counts (mod 2^64)
module chacha20_poly1305_mac_fmt (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    chacha20_poly1305_mac_fmt_if.slave        bus,
    output logic                              done,
    output logic                              error,
    output logic [63:0]                       aad_len,
    output logic [63:0]                       ct_len
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AAD  = 3'd1,
        S_CT   = 3'd2,
        S_LEN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic           out_valid_q, out_last_q;
    logic [127:0]   out_data_q;

    logic           in_ready_c, out_free, accept, out_hs, len_hs, load_len;
    logic           violation;
    logic [4:0]     bytes_eff;
    logic [127:0]   masked;

    // RFC 8439 length fields are little-endian; byte 0 of the block sits at the MSBs.
    function automatic logic [63:0] bswap64(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[63-8*i -: 8] = x[8*i +: 8];
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_AAD;
        end else begin
            case (state_q)
                S_AAD:   if (accept && bus.in_last) state_d = S_CT;
                S_CT:    if (accept && bus.in_last) state_d = S_LEN;
                S_LEN:   if (len_hs)                state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // Output / handshake decode
    always_comb begin
        out_free   = !out_valid_q || bus.out_ready;
        in_ready_c = ((state_q == S_AAD) || (state_q == S_CT)) && out_free;
        accept     = bus.in_valid && in_ready_c;
        out_hs     = out_valid_q && bus.out_ready;
        len_hs     = out_hs && out_last_q;
        // out_last_q is only ever set by the length load, so it doubles as "already loaded".
        load_len   = (state_q == S_LEN) && !out_last_q && out_free;
    end

    // Bad beats are still consumed as full 16-byte blocks so the stream stays aligned.
    always_comb begin
        violation = (bus.in_bytes > 5'd16) || (!bus.in_last && (bus.in_bytes != 5'd16));
        bytes_eff = violation ? 5'd16 : bus.in_bytes;
        masked    = '0;
        for (int i = 0; i < 16; i++) begin
            masked[127-8*i -: 8] = (5'(i) < bytes_eff) ? bus.in_data[127-8*i -: 8] : 8'h00;
        end
    end

    // Datapath and status registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            aad_len     <= '0;
            ct_len      <= '0;
        end else if (start) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            aad_len     <= '0;
            ct_len      <= '0;
        end else begin
            if (out_hs) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            if (len_hs) begin
                done <= 1'b1;
            end
            if (accept) begin
                if (violation) begin
                    error <= 1'b1;
                end
                // An empty final beat only closes the phase; nothing goes to Poly1305.
                if (bytes_eff != 5'd0) begin
                    out_data_q  <= masked;
                    out_valid_q <= 1'b1;
                    out_last_q  <= 1'b0;
                end
                if (state_q == S_AAD) begin
                    aad_len <= aad_len + {59'd0, bytes_eff};
                end else begin
                    ct_len  <= ct_len + {59'd0, bytes_eff};
                end
            end
            if (load_len) begin
                out_data_q  <= {bswap64(aad_len), bswap64(ct_len)};
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_chacha20_poly1305_mac_fmt.sv
// Scoreboard bench for the Poly1305 message formatter using directed vectors.
module tb_chacha20_poly1305_mac_fmt;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        done;
    logic        error;
    logic [63:0] aad_len;
    logic [63:0] ct_len;

    chacha20_poly1305_mac_fmt_if bus ();

    chacha20_poly1305_mac_fmt dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bus     (bus),
        .done    (done),
        .error   (error),
        .aad_len (aad_len),
        .ct_len  (ct_len)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   n_out  = 0;

    // RFC 8439 2.8.2 ciphertext (114 bytes); last beat padded with junk that must be masked.
    localparam logic [127:0] CT0 = 128'hd31a8d34648e60db7b86afbc53ef7ec2;
    localparam logic [127:0] CT1 = 128'ha4aded51296e08fea9e2b5a736ee62d6;
    localparam logic [127:0] CT2 = 128'h3dbea45e8ca9671282fafb69da92728b;
    localparam logic [127:0] CT3 = 128'h1a71de0a9e060b2905d6a5b67ecd3b36;
    localparam logic [127:0] CT4 = 128'h92ddbd7f2d778b8c9803aee328091b58;
    localparam logic [127:0] CT5 = 128'hfab324e4fad675945585808b4831d7bc;
    localparam logic [127:0] CT6 = 128'h3ff4def08e4b7a9de576d26586cec64b;
    localparam logic [127:0] CT7 = 128'h6116aaaaaaaaaaaaaaaaaaaaaaaaaaaa;
    localparam logic [127:0] CT7_EXP = 128'h61160000000000000000000000000000;
    localparam logic [127:0] AAD_IN  = 128'h50515253c0c1c2c3c4c5c6c7deadbeef;
    localparam logic [127:0] AAD_EXP = 128'h50515253c0c1c2c3c4c5c6c700000000;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: a block is taken when out_valid && out_ready at the coming edge, unless start discards it.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && !start && bus.out_valid && bus.out_ready) begin
            n_out++;
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL out_block: got %h last=%b, expected no block", bus.out_data, bus.out_last);
            end else begin
                e = sb.pop_front();
                if ({bus.out_data, bus.out_last} !== e) begin
                    fails++;
                    $display("FAIL out_block: got %h last=%b, expected %h last=%b",
                             bus.out_data, bus.out_last, e.data, e.last);
                end
            end
        end
    end

    // All stimulus tasks are entered and left 1 time unit after a rising edge.
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, input logic [4:0] n, input logic last,
                        input logic has_exp, input logic [127:0] exp);
        int k;
        k = 0;
        if (has_exp) sb.push_back({exp, 1'b0});
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_bytes = n;
        bus.in_last  = last;
        @(negedge clk);
        while (!bus.in_ready && k < 100) begin
            k++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: in_ready got 0, expected 1 within 100 cycles");
        end
        sync();
        bus.in_valid = 1'b0;
    endtask

    task automatic push_len(input logic [63:0] a_le, input logic [63:0] c_le);
        sb.push_back({a_le, c_le, 1'b1});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        sync();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!done && k < 100) begin
            k++;
            @(negedge clk);
        end
        chk(name, done, 1'b1);
        sync();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"},  bus.out_data,  0);
        chk({tag, "_out_last"},  bus.out_last,  0);
        chk({tag, "_done"},      done,          0);
        chk({tag, "_error"},     error,         0);
        chk({tag, "_aad_len"},   aad_len,       0);
        chk({tag, "_ct_len"},    ct_len,        0);
        chk({tag, "_in_ready"},  bus.in_ready,  0);
    endtask

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_bytes  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        sync();
        reset_n = 1'b1;
        sync();

        // RFC 8439 vector with a 5-cycle output stall after CT block 3
        n_out = 0;
        pulse_start();
        send(AAD_IN, 5'd12, 1'b1, 1'b1, AAD_EXP);
        send(CT0, 5'd16, 1'b0, 1'b1, CT0);
        send(CT1, 5'd16, 1'b0, 1'b1, CT1);
        send(CT2, 5'd16, 1'b0, 1'b1, CT2);
        send(CT3, 5'd16, 1'b0, 1'b1, CT3);
        bus.out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready",  bus.in_ready,  0);
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_out_data",  bus.out_data,  CT3);
        end
        sync();
        bus.out_ready = 1'b1;
        send(CT4, 5'd16, 1'b0, 1'b1, CT4);
        send(CT5, 5'd16, 1'b0, 1'b1, CT5);
        send(CT6, 5'd16, 1'b0, 1'b1, CT6);
        send(CT7, 5'd2,  1'b1, 1'b1, CT7_EXP);
        push_len(64'h0c00000000000000, 64'h7200000000000000);
        wait_done("rfc_done");
        chk("rfc_aad_len", aad_len, 64'd12);
        chk("rfc_ct_len",  ct_len,  64'd114);
        chk("rfc_n_out",   n_out,   10);
        chk("rfc_sb_empty", sb.size(), 0);

        // Empty AAD
        n_out = 0;
        pulse_start();
        send(128'h11111111111111111111111111111111, 5'd0, 1'b1, 1'b0, '0);
        send(128'h00112233445566778899aabbccddeeff, 5'd16, 1'b1, 1'b1,
             128'h00112233445566778899aabbccddeeff);
        push_len(64'h0, 64'h1000000000000000);
        wait_done("empty_done");
        chk("empty_n_out",   n_out,   2);
        chk("empty_aad_len", aad_len, 64'd0);
        chk("empty_ct_len",  ct_len,  64'd16);

        // Protocol error: non-last beat with 8 bytes is consumed as 16
        pulse_start();
        @(negedge clk);
        chk("err_clear_done", done, 0);
        sync();
        send(128'h0, 5'd0, 1'b1, 1'b0, '0);
        send(128'hf0e1d2c3b4a5968778695a4b3c2d1e0f, 5'd8, 1'b0, 1'b1,
             128'hf0e1d2c3b4a5968778695a4b3c2d1e0f);
        @(negedge clk);
        chk("err_set",      error,  1);
        chk("err_ct_len",   ct_len, 64'd16);
        sync();
        send(128'h0123456789abcdef0123456789abcdef, 5'd16, 1'b1, 1'b1,
             128'h0123456789abcdef0123456789abcdef);
        @(negedge clk);
        chk("err_sticky", error, 1);
        sync();
        push_len(64'h0, 64'h2000000000000000);
        wait_done("err_done");
        chk("err_ct_len_final", ct_len, 64'd32);
        pulse_start();
        @(negedge clk);
        chk("err_cleared", error,   0);
        chk("err_aad_len", aad_len, 64'd0);
        sync();

        // Restart while a CT block is pending
        pulse_start();
        send(128'haaaaaaaaaaaaaaaabbbbbbbbbbbbbbbb, 5'd16, 1'b1, 1'b1,
             128'haaaaaaaaaaaaaaaabbbbbbbbbbbbbbbb);
        send(128'hccccccccccccccccdddddddddddddddd, 5'd16, 1'b0, 1'b1,
             128'hccccccccccccccccdddddddddddddddd);
        bus.out_ready = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        chk("restart_pending", bus.out_valid, 1);
        sync();
        pulse_start();
        @(negedge clk);
        chk("restart_out_valid", bus.out_valid, 0);
        chk("restart_aad_len",   aad_len, 64'd0);
        chk("restart_ct_len",    ct_len,  64'd0);
        chk("restart_in_ready",  bus.in_ready, 1);
        sync();
        bus.out_ready = 1'b1;
        n_out = 0;
        send(128'h0102030405ffffffffffffffffffffff, 5'd5, 1'b1, 1'b1,
             128'h01020304050000000000000000000000);
        send(128'h0, 5'd0, 1'b1, 1'b0, '0);
        push_len(64'h0500000000000000, 64'h0);
        wait_done("restart_done");
        chk("restart_n_out", n_out, 2);

        // Reset while in LEN with the last CT block still pending
        pulse_start();
        send(128'h0, 5'd0, 1'b1, 1'b0, '0);
        bus.out_ready = 1'b0;
        send(128'h99999999999999999999999999999999, 5'd16, 1'b1, 1'b1,
             128'h99999999999999999999999999999999);
        void'(sb.pop_back());
        reset_n = 1'b0;
        sync();
        reset_n = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_len");
        bus.in_valid = 1'b1;
        bus.in_bytes = 5'd16;
        bus.in_last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready_idle", bus.in_ready, 0);
        end
        chk("rst_ignored_aad_len", aad_len, 64'd0);
        sync();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) sync();
        chk("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
